change_payout: RTL and testbench

- Downstream of the vending controller: takes the change amount it reports at the end of a transaction (sale or cancel) and pays it out coin by coin.
- Drives a coin hopper through a req/ack handshake, using the same coin encoding as the controller's coin input (01 = 5 rs, 10 = 10 rs).
- Pays greedily, 10 rs coins first, and falls back to 5 rs coins when the 10 rs hopper is empty.
- Reports done, fault and any amount still owed.

---
 rtl/change_payout.sv | 138 +++++++++++++
 tb/tb_change_payout.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/change_payout.sv
// change_payout: pays out a change amount coin by coin through a hopper
// req/ack handshake. Greedy 10 rs first, falls back to 5 rs when the 10 rs
// hopper is empty. Aborts with the unpaid remainder on ack timeout or when
// the residual cannot be paid.
module change_payout #(
  parameter int AMT_W       = 5,
  parameter int ACK_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             coin_ack,
  input  logic             hop10_empty,
  input  logic             hop5_empty,
  input  logic             fault_clr,
  output logic             coin_req,
  output logic [1:0]       coin_code,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] owed
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    REQ,
    GAP,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0]       CODE_5   = 2'b01;
  localparam logic [1:0]       CODE_10  = 2'b10;
  localparam logic [AMT_W-1:0] VAL_5    = AMT_W'(5);
  localparam logic [AMT_W-1:0] VAL_10   = AMT_W'(10);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] owed_q, owed_d;
  logic [1:0]       code_q, code_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [AMT_W-1:0] coin_val;

  assign coin_val = (code_q == CODE_10) ? VAL_10 : VAL_5;

  // State and datapath registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      owed_q  <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      owed_q  <= owed_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    owed_d  = owed_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (change_valid) begin
          rem_d   = change_amt;
          state_d = (change_amt == '0) ? DONE : SELECT;
        end
      end
      SELECT: begin
        cnt_d = '0;
        if (rem_q >= VAL_10 && !hop10_empty) begin
          code_d  = CODE_10;
          state_d = REQ;
        end else if (rem_q >= VAL_5 && !hop5_empty) begin
          code_d  = CODE_5;
          state_d = REQ;
        end else if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          owed_d  = rem_q;
          state_d = ERR;
        end
      end
      REQ: begin
        if (coin_ack) begin
          rem_d   = rem_q - coin_val;
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q == TO_LAST) begin
          // counter holds cycles already spent in REQ, so this is the last one
          cnt_d   = '0;
          owed_d  = rem_q;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        code_d  = '0;
        state_d = (rem_q == '0) ? DONE : SELECT;
      end
      DONE: begin
        state_d = IDLE;
      end
      ERR: begin
        if (fault_clr) begin
          owed_d  = '0;
          rem_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    coin_req  = (state_q == REQ);
    coin_code = (state_q == REQ) ? code_q : 2'b00;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    fault     = (state_q == ERR);
    owed      = (state_q == ERR) ? owed_q : '0;
  end

endmodule

// File: tb/tb_change_payout.sv
// Directed testbench for change_payout with hand-computed expectations.
module tb_change_payout;

  logic       clk;
  logic       rst;
  logic       change_valid;
  logic [4:0] change_amt;
  logic       coin_ack;
  logic       hop10_empty;
  logic       hop5_empty;
  logic       fault_clr;
  logic       coin_req;
  logic [1:0] coin_code;
  logic       busy;
  logic       done;
  logic       fault;
  logic [4:0] owed;

  int n_tests = 0;
  int n_fail  = 0;

  // results of the last payout run
  int codes[$];
  int paid;
  int dones;
  int req_cycles;
  int max_run;
  bit finished;

  change_payout #(
    .AMT_W(5),
    .ACK_TIMEOUT(15),
    .TO_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .change_valid(change_valid),
    .change_amt(change_amt),
    .coin_ack(coin_ack),
    .hop10_empty(hop10_empty),
    .hop5_empty(hop5_empty),
    .fault_clr(fault_clr),
    .coin_req(coin_req),
    .coin_code(coin_code),
    .busy(busy),
    .done(done),
    .fault(fault),
    .owed(owed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // advance one clock; sample point is 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a payout and act as the hopper until IDLE or ERR.
  // inj >= 0 pulses change_valid (amt 5) at that cycle while busy.
  task automatic pay(input int amt, input bit ack_on, input int inj);
    int run;
    codes.delete();
    paid = 0; dones = 0; req_cycles = 0; max_run = 0; run = 0;
    finished = 0;
    change_amt   = 5'(amt);
    change_valid = 1'b1;
    tick();
    change_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (coin_req) begin
        req_cycles++;
        run++;
        if (run > max_run) max_run = run;
        if (run == 1) begin
          codes.push_back(int'(coin_code));
          paid += (coin_code == 2'b10) ? 10 : (coin_code == 2'b01) ? 5 : 0;
        end
        coin_ack = ack_on;
      end else begin
        run      = 0;
        coin_ack = 1'b0;
      end
      if (done) dones++;
      if (fault || !busy) begin
        finished = 1;
        break;
      end
      if (c == inj) begin
        change_valid = 1'b1;
        change_amt   = 5'd5;
      end else begin
        change_valid = 1'b0;
      end
      tick();
    end
    coin_ack     = 1'b0;
    change_valid = 1'b0;
    chk("run_terminated", int'(finished), 1);
  endtask

  initial begin
    rst = 1'b1; change_valid = 1'b0; change_amt = '0; coin_ack = 1'b0;
    hop10_empty = 1'b0; hop5_empty = 1'b0; fault_clr = 1'b0;
    tick();
    tick();
    chk("rst_req",   int'(coin_req), 0);
    chk("rst_code",  int'(coin_code), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_owed",  int'(owed), 0);
    rst = 1'b0;
    tick();

    // 15 rs: a 10 then a 5
    pay(15, 1, -1);
    chk("p15_ncoins", codes.size(), 2);
    if (codes.size() == 2) begin
      chk("p15_first", codes[0], 2);
      chk("p15_second", codes[1], 1);
    end
    chk("p15_paid", paid, 15);
    chk("p15_reqlen", max_run, 1);
    chk("p15_done", dones, 1);
    chk("p15_fault", int'(fault), 0);
    chk("p15_owed", int'(owed), 0);

    // 20 rs with the 10 rs hopper empty: four 5s
    hop10_empty = 1'b1;
    pay(20, 1, -1);
    chk("p20e_ncoins", codes.size(), 4);
    chk("p20e_req5", req_cycles, 4);
    chk("p20e_paid", paid, 20);
    chk("p20e_done", dones, 1);
    hop10_empty = 1'b0;

    // 20 rs with both hoppers full: two 10s
    pay(20, 1, -1);
    chk("p20_ncoins", codes.size(), 2);
    if (codes.size() == 2) chk("p20_code", codes[1], 2);
    chk("p20_paid", paid, 20);

    // 7 rs: one 5 then residual 2 owed
    pay(7, 1, -1);
    chk("p7_paid", paid, 5);
    chk("p7_fault", int'(fault), 1);
    chk("p7_owed", int'(owed), 2);
    chk("p7_nodone", dones, 0);
    // new transaction ignored while faulted
    change_valid = 1'b1; change_amt = 5'd10;
    tick();
    change_valid = 1'b0;
    tick();
    chk("err_hold_fault", int'(fault), 1);
    chk("err_hold_owed", int'(owed), 2);
    chk("err_hold_req", int'(coin_req), 0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_fault", int'(fault), 0);
    chk("clr_owed", int'(owed), 0);
    chk("clr_busy", int'(busy), 0);

    // 10 rs, never acked: 15 request cycles, then fault
    pay(10, 0, -1);
    chk("to_reqcycles", req_cycles, 15);
    chk("to_fault", int'(fault), 1);
    chk("to_owed", int'(owed), 10);
    chk("to_req_low", int'(coin_req), 0);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;

    // 5 rs with the 5 rs hopper empty: immediate fault
    hop5_empty = 1'b1;
    pay(5, 1, -1);
    chk("e5_paid", paid, 0);
    chk("e5_owed", int'(owed), 5);
    hop5_empty = 1'b0;
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;

    // zero amount: done right after the strobe edge, no coin
    change_amt = 5'd0; change_valid = 1'b1;
    tick();
    change_valid = 1'b0;
    chk("z_done", int'(done), 1);
    chk("z_req", int'(coin_req), 0);
    tick();
    chk("z_done_once", int'(done), 0);
    chk("z_idle", int'(busy), 0);

    // 30 rs with a stray strobe while busy
    pay(30, 1, 2);
    chk("p30_paid", paid, 30);
    chk("p30_ncoins", codes.size(), 3);
    chk("p30_done", dones, 1);
    tick();
    chk("p30_idle", int'(busy), 0);

    // reset during a request
    change_amt = 5'd10; change_valid = 1'b1;
    tick();
    change_valid = 1'b0;
    tick();
    chk("mid_req", int'(coin_req), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_req", int'(coin_req), 0);
    chk("mr_code", int'(coin_code), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_fault", int'(fault), 0);
    chk("mr_owed", int'(owed), 0);
    tick();
    chk("mr_stay_idle", int'(busy), 0);
    pay(5, 1, -1);
    chk("after_rst_paid", paid, 5);
    chk("after_rst_done", dones, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
